instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
- Writer side of the instruction memory's load port.
- Receives a byte stream from the UART receiver, packs 4 bytes into one 32-bit instruction word (MSB first), and drives the memory's write enable, write address and write data, one word per write pulse.
- Stops on a halt word or when memory is full, then reports completion to the debug/control unit, which releases the CPU.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, width of incoming stream byte.
- ADDR_BITS, 10, memory write address width.
- MAX_WORDS, 1024, memory depth in words; must be ≤ 2**ADDR_BITS.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker.
- TIMEOUT_CYCLES, 100000, idle cycles before abort; used only with the optional feature.

Ports:
- i_clock  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_start  in  1  single-cycle pulse; begins a load from address 0.
- i_rx_data  in  BYTE_WIDTH  received byte.
- i_rx_valid  in  1  i_rx_data valid this cycle; one byte is accepted per asserted cycle.
- o_write_enable  out  1  memory write strobe.
- o_write_addr  out  ADDR_BITS  memory word address.
- o_data  out  DATA_WIDTH  word to write.
- o_busy  out  1  load in progress.
- o_done  out  1  load finished; held until the next i_start.
- o_overflow  out  1  memory filled without a halt word.
- o_word_count  out  ADDR_BITS+1  number of words written, halt word included.
- o_error  out  1  timeout abort; present only with LOADER_TIMEOUT_EN.

Behaviour:
- Reset (i_reset=0 at an edge): state IDLE; every output 0, including o_error; byte counter 0; shift register 0. Reset mid-load abandons the partial word and produces no write.
- States and transitions:
  - IDLE: i_start goes to LOAD.
  - LOAD: packs bytes and writes words; exits to DONE on halt or full.
  - DONE: i_start goes to LOAD.
- Entry into LOAD (from IDLE or DONE): clears o_write_addr, o_word_count, byte counter, o_done, o_overflow and o_error. Sets o_busy=1 from the next cycle.
- IDLE ignores i_rx_valid.
- In LOAD, each i_rx_valid shifts i_rx_data into the LSB of the shift register, so the first byte ends up in the MSBs.
- Accepting the 4th byte of a word at edge N makes the following true at edge N+1, for exactly one cycle:
  - o_write_enable=1;
  - o_data = the assembled word;
  - o_write_addr = current word address.
  The byte counter returns to 0, so the next word's first byte can arrive in the very next cycle with no dead cycle.
- After each write, o_word_count increments by 1 and o_write_addr increments by 1.
- If the written word equals HALT_WORD: the word is still written, then at the next edge the block enters DONE with o_done=1 and o_busy=0.
- If the written address is MAX_WORDS-1 and the word is not HALT_WORD: enter DONE with o_done=1 and o_overflow=1. o_write_addr never wraps.
- Bytes arriving in the cycle of the final write, or at any time in DONE, are dropped.
- i_start while in LOAD is ignored.
- i_start and i_rx_valid in the same cycle in IDLE/DONE: i_start is taken; the byte is dropped.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro name: LOADER_TIMEOUT_EN.
- When defined:
  - A counter runs in LOAD and clears on each accepted byte.
  - When it reaches TIMEOUT_CYCLES, the block enters DONE with o_error=1 and o_done=1.
  - The partial word is discarded; no write is issued.
  - o_error clears on the next i_start or on reset.
- When undefined: no counter is present, o_error is not a port, and LOAD waits indefinitely.

Test Plan:
- Reset behaviour: hold i_reset=0 for 3 cycles while driving i_rx_valid=1 and i_start=1 → all outputs 0; no write strobes.
- Back-to-back program load: i_start, then bytes 0x20,0x01,0x00,0x05, 0x00,0x00,0x00,0x00, 0xFF,0xFF,0xFF,0xFF on consecutive cycles → three expected writes:
  - addr0=0x20010005;
  - addr1=0x00000000;
  - addr2=0xFFFFFFFF.
  Then o_done=1, o_word_count=3, o_overflow=0, o_busy=0.
- Gapped stream: same bytes with 0-5 random idle cycles between them → identical writes; each o_write_enable pulse is exactly 1 cycle and arrives 1 cycle after the 4th byte.
- Overflow: MAX_WORDS=4, stream 16 bytes of 0x11 → four writes, addr 0-3, each 0x11111111. Then o_overflow=1, o_done=1, o_word_count=4; a 17th byte causes no write.
- Reset mid-word, then restart:
  - send 2 bytes, assert reset for 1 cycle → no write;
  - i_start, then 0xFF×4 → write addr0=0xFFFFFFFF, o_word_count=1;
  - i_start again → o_done clears and the next write goes to addr 0.
- Timeout (LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=50): i_start, 2 bytes, then idle for 50 cycles → o_error=1, o_done=1, no write. The next i_start clears o_error.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Packs the UART byte stream into instruction words for the imem load port.
// Optional idle-timeout abort is enabled with LOADER_TIMEOUT_EN.
module instr_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_BITS = 10,
  parameter int MAX_WORDS = 1024,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = 32'hFFFFFFFF,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [BYTE_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_write_enable,
  output logic [ADDR_BITS-1:0]  o_write_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
`ifdef LOADER_TIMEOUT_EN
  output logic                  o_error,
`endif
  output logic [ADDR_BITS:0]    o_word_count
);

  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int BCW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR =
    ADDR_BITS'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic                  we_q, we_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic [ADDR_BITS:0]    cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  is_halt;
  logic                  wr_last;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic          err_q, err_d;
  logic [TW-1:0] tmr_q, tmr_d;
`endif

  assign is_halt = (data_q == HALT_WORD);
  // The word on the bus this cycle ends the load.
  assign wr_last = we_q && (is_halt || addr_q == LAST_ADDR);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      shift_q <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      err_q   <= 1'b0;
      tmr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
`ifdef LOADER_TIMEOUT_EN
      err_q   <= err_d;
      tmr_q   <= tmr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
`ifdef LOADER_TIMEOUT_EN
    err_d   = err_q;
    tmr_d   = tmr_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          shift_d = '0;
          bcnt_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
`ifdef LOADER_TIMEOUT_EN
          err_d   = 1'b0;
          tmr_d   = '0;
`endif
        end
      end
      S_LOAD: begin
        // Count and address advance once the strobe has been seen.
        if (we_q) begin
          cnt_d = cnt_q + 1'b1;
          if (addr_q != LAST_ADDR) begin
            addr_d = addr_q + 1'b1;
          end
        end
        if (wr_last) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ovf_d   = !is_halt;
        end else if (i_rx_valid) begin
          shift_d = {shift_q[DATA_WIDTH-BYTE_WIDTH-1:0], i_rx_data};
`ifdef LOADER_TIMEOUT_EN
          tmr_d   = '0;
`endif
          if (bcnt_q == LAST_BYTE) begin
            we_d   = 1'b1;
            data_d = shift_d;
            bcnt_d = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
`ifdef LOADER_TIMEOUT_EN
        else if (tmr_q == TMO_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          bcnt_d  = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_write_enable = we_q;
  assign o_write_addr   = addr_q;
  assign o_data         = data_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_overflow     = ovf_q;
  assign o_word_count   = cnt_q;
`ifdef LOADER_TIMEOUT_EN
  assign o_error        = err_q;
`endif

endmodule
